// File: rtl/mult_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared types and constants for the serial-input shift-add multiplier
// sequencer: controller state encoding, default operand width and the
// sizing rule for the step/bit counters.
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_MUL,
    ST_DONE
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // One extra bit so a counter can hold the value WIDTH itself.
  function automatic int step_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DEF_STEP_W = step_w(DEF_WIDTH);

endpackage

// File: rtl/mult_seq_ctrl_serial_deser.sv
// ---------------------------------------------------------------------------
// serial_deser
// WIDTH-bit MSB-first serial-to-parallel shift register with its own bit
// counter. o_last flags the cycle in which the final bit of a word is being
// shifted in, so the controller can advance on the same edge.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset (clears data and count)
//   i_clr   restart the bit count (data is left untouched)
//   i_en    shift i_din in this cycle
//   i_din   serial data bit
//   o_data  parallel word (live while shifting)
//   o_last  i_en is high and this is the WIDTH-th bit of the word
// ---------------------------------------------------------------------------
module serial_deser
  import mult_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = step_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);

  localparam logic [STEP_W-1:0] LAST_BIT = STEP_W'(WIDTH - 1);

  logic [WIDTH-1:0]  r_data;
  logic [STEP_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_data <= {r_data[WIDTH-2:0], i_din};
      // Wrap so the lane is ready for the next word without an explicit clear.
      r_cnt  <= (r_cnt == LAST_BIT) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_last = i_en && (r_cnt == LAST_BIT);

endmodule

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
// Sequencer for the serial-input multiplier stage. Deserializes operand A
// then operand B (MSB first) from din, runs a WIDTH-step shift-add multiply
// and offers the 2*WIDTH-bit product on a valid/ready handshake. Counts
// completed handshakes with a saturating counter.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        begin an operation (only honoured in IDLE)
//   abort        cancel the current operation (no effect in IDLE)
//   din          serial operand bits: A[W-1..0] then B[W-1..0]
//   busy         high whenever the sequencer is not IDLE
//   op_a, op_b   deserialized operands (live while loading)
//   dout_valid   product available
//   dout_ready   consumer accepts the product
//   product      unsigned A*B
//   done_cnt     completed handshakes, saturating at all-ones
// ---------------------------------------------------------------------------
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               din,
  output logic               busy,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [CNT_W-1:0]   done_cnt
);

  localparam int STEP_W = step_w(WIDTH);
  localparam int IDX_W  = $clog2(WIDTH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  state_t             r_state;
  logic               r_busy;
  logic [STEP_W-1:0]  r_step;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic               r_valid;
  logic [CNT_W-1:0]   r_done_cnt;

  logic               w_start_go;
  logic [1:0]         w_lane_en;
  logic [1:0]         w_lane_last;
  logic [WIDTH-1:0]   w_lane_data [2];
  logic [2*WIDTH-1:0] w_op_a_ext;
  logic [2*WIDTH-1:0] w_partial;
  logic [2*WIDTH-1:0] w_sum;

  // Both lane counters restart when an operation is accepted, so a word
  // left half-loaded by an abort cannot skew the next one.
  assign w_start_go   = (r_state == ST_IDLE) && start;
  assign w_lane_en[0] = (r_state == ST_LOAD_A) && !abort;
  assign w_lane_en[1] = (r_state == ST_LOAD_B) && !abort;

  // Lane 0 holds operand A, lane 1 operand B.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    serial_deser #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
    ) u_deser (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_start_go),
      .i_en   (w_lane_en[gi]),
      .i_din  (din),
      .o_data (w_lane_data[gi]),
      .o_last (w_lane_last[gi])
    );
  end

  // Partial product for the current step, at full product width so the
  // running sum can never overflow.
  assign w_op_a_ext = {{WIDTH{1'b0}}, w_lane_data[0]};
  assign w_partial  = w_lane_data[1][r_step[IDX_W-1:0]] ? (w_op_a_ext << r_step) : '0;
  assign w_sum      = r_acc + w_partial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_step     <= '0;
      r_acc      <= '0;
      r_product  <= '0;
      r_valid    <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD_A;
            r_busy  <= 1'b1;
            r_step  <= '0;
          end
        end
        ST_LOAD_A: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_lane_last[0]) begin
            r_state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_lane_last[1]) begin
            r_state <= ST_MUL;
            r_acc   <= '0;
            r_step  <= '0;
          end
        end
        ST_MUL: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc  <= w_sum;
            r_step <= r_step + 1'b1;
            if (r_step == LAST_STEP) begin
              r_product <= w_sum;
              r_valid   <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Abort wins over a simultaneous accept: product is dropped uncounted.
          if (abort) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_valid && dout_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (r_done_cnt != '1) r_done_cnt <= r_done_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign op_a       = w_lane_data[0];
  assign op_b       = w_lane_data[1];
  assign dout_valid = r_valid;
  assign product    = r_product;
  assign done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_ctrl
// Scoreboard bench: each issued operation pushes its expected product and
// the expected pre-handshake done_cnt; a negedge monitor pops and compares
// on every accepted product. Directed checks cover reset, latency,
// backpressure, abort, asynchronous reset and counter saturation.
// ---------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       din = 1'b0;
  logic       busy;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic [7:0] product;
  logic [7:0] done_cnt;

  typedef struct {
    logic [7:0] prod;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] model_cnt = 8'd0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .din        (din),
    .busy       (busy),
    .op_a       (op_a),
    .op_b       (op_b),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .product    (product),
    .done_cnt   (done_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake happens on the next edge when valid & ready & !abort.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dout_valid && dout_ready && !abort) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_product: got 0x%0h, expected no output", product);
      end else begin
        e = sb_q.pop_front();
        check("product", {24'd0, product}, {24'd0, e.prod});
        check("done_cnt_pre", {24'd0, done_cnt}, {24'd0, e.cnt});
        $display("handshake product=0x%02h done_cnt=%0d", product, done_cnt);
      end
    end
  end

  // Start pulse followed by A then B, MSB first. din is 1 in the start cycle
  // to show that bit is ignored. Returns at the negedge after the last bit.
  task automatic load_ops(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk); start = 1'b1; din = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 3; i >= 0; i--) begin din = a[i]; @(negedge clk); end
    for (int i = 3; i >= 0; i--) begin din = b[i]; @(negedge clk); end
    din = 1'b0;
  endtask

  // Called right after load_ops (8 edges after the start edge).
  task automatic wait_valid(output int lat, output time t);
    int c;
    c = 8;
    while (!dout_valid && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    lat = c;
    t   = $time;
    if (!dout_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL valid_timeout: got no dout_valid after %0d cycles, expected 12", c);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.prod = {4'd0, a} * {4'd0, b};
    e.cnt  = model_cnt;
    sb_q.push_back(e);
    if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
  endtask

  // Full operation with dout_ready high; returns #1 after the handshake edge.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output time t);
    int lat;
    push_exp(a, b);
    load_ops(a, b);
    check("op_a", {28'd0, op_a}, {28'd0, a});
    check("op_b", {28'd0, op_b}, {28'd0, b});
    wait_valid(lat, t);
    check("latency", lat, 12);
    @(posedge clk); #1;
  endtask

  initial begin
    time t1, t2;
    int  lat;

    // Reset state
    @(posedge clk); #2;
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_valid", {31'd0, dout_valid}, 0);
    check("rst_op_a",  {28'd0, op_a}, 0);
    check("rst_op_b",  {28'd0, op_b}, 0);
    check("rst_product", {24'd0, product}, 0);
    check("rst_done_cnt", {24'd0, done_cnt}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Basic multiply 0xB * 0x6
    run_op(4'hB, 4'h6, t1);
    check("done_cnt_basic", {24'd0, done_cnt}, 1);

    // Extremes and back-to-back spacing
    run_op(4'hF, 4'hF, t1);
    run_op(4'h0, 4'h9, t2);
    check("b2b_spacing_ns", 32'(t2 - t1), 140);
    check("done_cnt_b2b", {24'd0, done_cnt}, 3);

    // Backpressure with an ignored start pulse while waiting
    dout_ready = 1'b0;
    push_exp(4'hB, 4'h6);
    load_ops(4'hB, 4'h6);
    wait_valid(lat, t1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = (i == 2);
      @(posedge clk); #1;
      check("bp_valid", {31'd0, dout_valid}, 1);
      check("bp_product", {24'd0, product}, 32'h42);
    end
    dout_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", {31'd0, dout_valid}, 0);
    check("bp_busy", {31'd0, busy}, 0);
    check("bp_done_cnt", {24'd0, done_cnt}, 4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_start_ignored", {31'd0, busy}, 0);
    end

    // Abort in the second LOAD_B cycle
    @(negedge clk); start = 1'b1; din = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin din = 1'b1; @(negedge clk); end
    din = 1'b0; @(negedge clk);
    din = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_valid", {31'd0, dout_valid}, 0);
    check("abort_done_cnt", {24'd0, done_cnt}, 4);
    @(negedge clk); abort = 1'b0; din = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", {31'd0, dout_valid}, 0);
    end
    run_op(4'h7, 4'h3, t1);

    // Abort in DONE beats a simultaneous dout_ready
    dout_ready = 1'b0;
    load_ops(4'h9, 4'h9);
    wait_valid(lat, t1);
    abort = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("done_abort_valid", {31'd0, dout_valid}, 0);
    check("done_abort_cnt", {24'd0, done_cnt}, 5);
    check("done_abort_busy", {31'd0, busy}, 0);

    // Asynchronous reset in the middle of MUL
    load_ops(4'h9, 4'h7);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_busy",  {31'd0, busy}, 0);
    check("arst_valid", {31'd0, dout_valid}, 0);
    check("arst_op_a",  {28'd0, op_a}, 0);
    check("arst_op_b",  {28'd0, op_b}, 0);
    check("arst_product", {24'd0, product}, 0);
    check("arst_done_cnt", {24'd0, done_cnt}, 0);
    @(negedge clk); rst = 1'b0;
    sb_q.delete();
    model_cnt = 8'd0;
    run_op(4'h3, 4'h5, t1);
    check("post_rst_product", {24'd0, product}, 32'h0F);

    // Saturation: 260 more completions on top of the one above
    for (int i = 0; i < 260; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      run_op(iv[3:0], iv[7:4] ^ iv[3:0], t1);
    end
    check("sat_done_cnt", {24'd0, done_cnt}, 32'hFF);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
